// File: rtl/reg_file_cc.sv
// Register file and NZP/BEN condition-code unit for the SLC3 datapath.
// Eight general registers with two combinational read ports; NZP loaded from BUS, BEN from IR nzp mask.
module reg_file_cc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] BUS,
  input  logic             LD_REG,
  input  logic [2:0]       DR,
  input  logic [2:0]       SR1,
  input  logic [2:0]       SR2,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic [2:0]       IR_NZP,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  output logic [2:0]       NZP,
  output logic             BEN
);

  logic [WIDTH-1:0] regs [NREG];
  logic             n_c;
  logic             z_c;
  logic             p_c;
  logic             ben_c;

  // Condition codes from the bus, two's-complement sign
  always_comb begin
    n_c   = BUS[WIDTH-1];
    z_c   = (BUS == '0);
    p_c   = !n_c && !z_c;
    // Uses the pre-edge NZP so a same-edge LD_CC does not affect BEN
    ben_c = |(IR_NZP & NZP);
  end

  // Register file storage
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (LD_REG) begin
      regs[DR] <= BUS;
    end
  end

  // NZP and BEN state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      NZP <= 3'b000;
      BEN <= 1'b0;
    end else begin
      if (LD_CC) begin
        NZP <= {n_c, z_c, p_c};
      end
      if (LD_BEN) begin
        BEN <= ben_c;
      end
    end
  end

  assign SR1_OUT = regs[SR1];
  assign SR2_OUT = regs[SR2];

endmodule

// File: tb/tb_reg_file_cc.sv
// Self-checking bench for reg_file_cc: scoreboard queue of expected values per scenario.
module tb_reg_file_cc;

  logic        Clk;
  logic        Reset;
  logic [15:0] BUS;
  logic        LD_REG;
  logic [2:0]  DR;
  logic [2:0]  SR1;
  logic [2:0]  SR2;
  logic        LD_CC;
  logic        LD_BEN;
  logic [2:0]  IR_NZP;
  logic [15:0] SR1_OUT;
  logic [15:0] SR2_OUT;
  logic [2:0]  NZP;
  logic        BEN;

  int n_cmp;
  int n_err;
  logic [15:0] exp_q [$];
  logic [15:0] exp_v;
  logic [15:0] model_r [8];

  reg_file_cc #(.WIDTH(16), .NREG(8)) dut (
    .Clk(Clk), .Reset(Reset), .BUS(BUS), .LD_REG(LD_REG), .DR(DR),
    .SR1(SR1), .SR2(SR2), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .IR_NZP(IR_NZP),
    .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .NZP(NZP), .BEN(BEN)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One rising edge, then deassert all loads
  task automatic tick();
    @(posedge Clk);
    #1;
    Reset  = 1'b0;
    LD_REG = 1'b0;
    LD_CC  = 1'b0;
    LD_BEN = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] d, input logic [15:0] v);
    LD_REG = 1'b1;
    DR     = d;
    BUS    = v;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; LD_REG = 1'b1; DR = 3'd1; BUS = 16'hAAAA; LD_CC = 1'b1; LD_BEN = 1'b1;
    IR_NZP = 3'b111;
    tick();
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0000);
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i);
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (SR1_OUT !== exp_v) begin
        n_err++;
        $display("FAIL reset_r%0d: got %h want %h", i, SR1_OUT, exp_v);
      end
    end
    n_cmp++;
    if (NZP !== 3'b000) begin n_err++; $display("FAIL reset_nzp: got %b want 000", NZP); end
    n_cmp++;
    if (BEN !== 1'b0) begin n_err++; $display("FAIL reset_ben: got %b want 0", BEN); end
  endtask

  task automatic test_write_basic();
    write_reg(3'd3, 16'h1234);
    SR1 = 3'd3; SR2 = 3'd2;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h0000);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (SR1_OUT !== exp_v) begin n_err++; $display("FAIL write_sr1: got %h want %h", SR1_OUT, exp_v); end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (SR2_OUT !== exp_v) begin n_err++; $display("FAIL write_sr2: got %h want %h", SR2_OUT, exp_v); end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i);
      SR2 = 3'(7 - i);
      exp_q.push_back(16'h1000 + 16'(i));
      exp_q.push_back(16'h1000 + 16'(7 - i));
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (SR1_OUT !== exp_v) begin n_err++; $display("FAIL sweep_sr1_%0d: got %h want %h", i, SR1_OUT, exp_v); end
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (SR2_OUT !== exp_v) begin n_err++; $display("FAIL sweep_sr2_%0d: got %h want %h", 7 - i, SR2_OUT, exp_v); end
    end
    // LD_REG low must not change anything
    LD_REG = 1'b0; DR = 3'd2; BUS = 16'hDEAD;
    @(posedge Clk); #1;
    SR1 = 3'd2; SR2 = 3'd2;
    exp_q.push_back(16'h1002);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (SR1_OUT !== exp_v || SR2_OUT !== exp_v) begin
      n_err++;
      $display("FAIL no_write_hold: got %h/%h want %h", SR1_OUT, SR2_OUT, exp_v);
    end
  endtask

  task automatic test_no_bypass();
    write_reg(3'd5, 16'h0001);
    SR1 = 3'd5;
    LD_REG = 1'b1; DR = 3'd5; BUS = 16'hBEEF;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'hBEEF);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (SR1_OUT !== exp_v) begin n_err++; $display("FAIL bypass_before: got %h want %h", SR1_OUT, exp_v); end
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (SR1_OUT !== exp_v) begin n_err++; $display("FAIL bypass_after: got %h want %h", SR1_OUT, exp_v); end
  endtask

  task automatic test_cc();
    logic [15:0] bus_v [4];
    logic        ld_v  [4];
    bus_v = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0000};
    ld_v  = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_q.push_back(16'(3'b100));
    exp_q.push_back(16'(3'b010));
    exp_q.push_back(16'(3'b001));
    exp_q.push_back(16'(3'b001));
    for (int i = 0; i < 4; i++) begin
      BUS = bus_v[i];
      LD_CC = ld_v[i];
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (NZP !== exp_v[2:0]) begin n_err++; $display("FAIL cc_%0d: got %b want %b", i, NZP, exp_v[2:0]); end
    end
  endtask

  task automatic test_ben();
    BUS = 16'h0000; LD_CC = 1'b1;
    tick();
    IR_NZP = 3'b010; LD_BEN = 1'b1;
    exp_q.push_back(16'h0001);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (BEN !== exp_v[0]) begin n_err++; $display("FAIL ben_z: got %b want %b", BEN, exp_v[0]); end
    BUS = 16'h0005; LD_CC = 1'b1; LD_BEN = 1'b1; IR_NZP = 3'b001;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'(3'b001));
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (BEN !== exp_v[0]) begin n_err++; $display("FAIL ben_old_nzp: got %b want %b", BEN, exp_v[0]); end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (NZP !== exp_v[2:0]) begin n_err++; $display("FAIL ben_new_nzp: got %b want %b", NZP, exp_v[2:0]); end
    LD_BEN = 1'b1;
    exp_q.push_back(16'h0001);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (BEN !== exp_v[0]) begin n_err++; $display("FAIL ben_p: got %b want %b", BEN, exp_v[0]); end
    // BEN holds when LD_BEN low even if mask would clear it
    IR_NZP = 3'b100;
    exp_q.push_back(16'h0001);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (BEN !== exp_v[0]) begin n_err++; $display("FAIL ben_hold: got %b want %b", BEN, exp_v[0]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) model_r[i] = 16'h1000 + 16'(i);
    model_r[5] = 16'hBEEF;
    for (int k = 0; k < 24; k++) begin
      logic [2:0]  d;
      logic [15:0] v;
      d = 3'($urandom_range(0, 7));
      v = 16'($urandom);
      write_reg(d, v);
      model_r[d] = v;
    end
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(i);
      exp_q.push_back(model_r[i]);
      #1;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (SR1_OUT !== exp_v || SR2_OUT !== exp_v) begin
        n_err++;
        $display("FAIL b2b_r%0d: got %h/%h want %h", i, SR1_OUT, SR2_OUT, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    write_reg(3'd0, 16'h5555);
    Reset = 1'b1; LD_REG = 1'b1; DR = 3'd0; BUS = 16'hFFFF; LD_CC = 1'b1; LD_BEN = 1'b1;
    IR_NZP = 3'b111;
    tick();
    SR1 = 3'd0; SR2 = 3'd3;
    exp_q.push_back(16'h0000);
    #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (SR1_OUT !== exp_v || SR2_OUT !== exp_v) begin
      n_err++;
      $display("FAIL midreset_regs: got %h/%h want %h", SR1_OUT, SR2_OUT, exp_v);
    end
    n_cmp++;
    if (NZP !== 3'b000) begin n_err++; $display("FAIL midreset_nzp: got %b want 000", NZP); end
    n_cmp++;
    if (BEN !== 1'b0) begin n_err++; $display("FAIL midreset_ben: got %b want 0", BEN); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    Reset = 1'b0; BUS = '0; LD_REG = 1'b0; DR = '0; SR1 = '0; SR2 = '0;
    LD_CC = 1'b0; LD_BEN = 1'b0; IR_NZP = '0;
    @(negedge Clk);
    test_reset();
    test_write_basic();
    test_sweep();
    test_no_bypass();
    test_cc();
    test_ben();
    test_back_to_back();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
